// File: rtl/dmux_stream_pkg.sv
// Shared defaults and pointer-width helper for the dmux_stream slice.
package dmux_stream_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEL_W = 2;
   localparam int DEF_DEPTH = 2;

   // Pointers carry one wrap bit above the index bits.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dmux_fifo.sv
// Per-channel FIFO with wrap-bit pointers; storage is cleared on reset so the
// head word reads 0 while empty after reset.
module dmux_fifo
   import dmux_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign empty     = (wptr == rptr);
   assign head_data = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push && !full) begin
            mem[wptr[AW-1:0]] <= push_data;
            wptr              <= wptr + PW'(1);
         end
         if (pop && !empty) rptr <= rptr + PW'(1);
      end
   end

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer with one FIFO per channel.
// Optional broadcast input is enabled with DMUX_STREAM_BCAST_EN.
module dmux_stream
   import dmux_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = DEF_SEL_W,
   parameter int DEPTH = DEF_DEPTH,
   localparam int N    = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_valid,
`ifdef DMUX_STREAM_BCAST_EN
   input  logic               in_bcast,
`endif
   output logic               in_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready
);

   // Handshakes: input word transfers on in_valid && in_ready at a rising edge;
   // channel k head transfers on out_valid[k] && out_ready[k]. in_ready looks
   // only at FIFO fullness, never at out_ready, so there is no pass-through.
   logic         bcast;
   logic [N-1:0] full;
   logic [N-1:0] empty;
   logic [N-1:0] push;

`ifdef DMUX_STREAM_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   assign in_ready = bcast ? ~|full : ~full[in_sel];

   for (genvar g = 0; g < N; g++) begin : g_chan
      assign push[g]      = in_valid && in_ready && (bcast || (in_sel == SEL_W'(g)));
      assign out_valid[g] = ~empty[g];

      dmux_fifo #(
         .WIDTH(WIDTH),
         .DEPTH(DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push[g]),
         .push_data(in_data),
         .full     (full[g]),
         .pop      (out_ready[g]),
         .head_data(out_data[g*WIDTH +: WIDTH]),
         .empty    (empty[g])
      );
   end

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: vector table plus hand sequences, with a per-channel
// expected-word queue checked whenever a channel pops.
module tb_dmux_stream;

   localparam int W = 16;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   in_data = '0;
   logic [1:0]     in_sel = '0;
   logic           in_valid = 1'b0;
`ifdef DMUX_STREAM_BCAST_EN
   logic           in_bcast = 1'b0;
`endif
   logic           in_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready = '0;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[N][$];

   dmux_stream dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
`ifdef DMUX_STREAM_BCAST_EN
      .in_bcast (in_bcast),
`endif
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_queues();
      for (int k = 0; k < N; k++) exp_q[k].delete();
   endtask

   // ---------------- scoreboard monitor ----------------
   // Inputs are stable from posedge+1, so at negedge the coming edge's
   // handshakes are known: compare pops first, then queue the accepted word.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(exp_q[k].size() != 0));
            if (out_valid[k] && out_ready[k] && exp_q[k].size() != 0)
               check($sformatf("pop ch%0d", k), 64'(out_data[k*W +: W]), 64'(exp_q[k].pop_front()));
         end
         if (in_valid && in_ready) begin
`ifdef DMUX_STREAM_BCAST_EN
            if (in_bcast) for (int k = 0; k < N; k++) exp_q[k].push_back(in_data);
            else exp_q[in_sel].push_back(in_data);
`else
            exp_q[in_sel].push_back(in_data);
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      in_valid = 1'b0;
      in_data  = '0;
      in_sel   = '0;
`ifdef DMUX_STREAM_BCAST_EN
      in_bcast = 1'b0;
`endif
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] sel, input logic [W-1:0] data);
      in_sel   = sel;
      in_data  = data;
      in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int cyc = 0;
      idle_inputs();
      out_ready = '1;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
             && cyc < 50) begin
         next_cycle();
         cyc++;
      end
      check({name, " drained"}, 64'(out_valid), 64'(0));
   endtask

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] data;
      logic         valid;
      logic [3:0]   ordy;
      logic         exp_ready;
      logic [3:0]   exp_ovalid;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic [1:0] sel, input logic [W-1:0] data, input logic valid,
                               input logic [3:0] ordy, input logic er, input logic [3:0] eov);
      vec_t v;
      v.sel = sel; v.data = data; v.valid = valid; v.ordy = ordy;
      v.exp_ready = er; v.exp_ovalid = eov;
      return v;
   endfunction

   initial begin
      // unicast routing, all consumers ready: one channel valid per cycle
      vecs[0]  = mk(2'd0, 16'hA000, 1'b1, 4'b1111, 1'b1, 4'b0000);
      vecs[1]  = mk(2'd1, 16'hA001, 1'b1, 4'b1111, 1'b1, 4'b0001);
      vecs[2]  = mk(2'd2, 16'hA002, 1'b1, 4'b1111, 1'b1, 4'b0010);
      vecs[3]  = mk(2'd3, 16'hA003, 1'b1, 4'b1111, 1'b1, 4'b0100);
      vecs[4]  = mk(2'd0, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'b1000);
      vecs[5]  = mk(2'd0, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'b0000);
      // back-pressure isolation: channel 1 stalled
      vecs[6]  = mk(2'd1, 16'hB001, 1'b1, 4'b1101, 1'b1, 4'b0000);
      vecs[7]  = mk(2'd1, 16'hB002, 1'b1, 4'b1101, 1'b1, 4'b0010);
      vecs[8]  = mk(2'd1, 16'hB003, 1'b1, 4'b1101, 1'b0, 4'b0010);
      vecs[9]  = mk(2'd3, 16'hB004, 1'b1, 4'b1101, 1'b1, 4'b0010);
      vecs[10] = mk(2'd0, 16'h0000, 1'b0, 4'b1101, 1'b1, 4'b1010);
      vecs[11] = mk(2'd0, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'b0010);
      vecs[12] = mk(2'd0, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'b0010);
      vecs[13] = mk(2'd0, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'b0000);

      // ---------------- reset ----------------
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset out_data", out_data, 64'(0));
      check("reset in_ready", 64'(in_ready), 64'(1));
      next_cycle();

      // ---------------- reset mid-stream ----------------
      out_ready = '0;
      send(2'd2, 16'h1111);
      send(2'd2, 16'h2222);
      check("ch2 holds two", 64'(out_data[2*W +: W]), 64'(16'h1111));
      #2 rst = 1'b1;
      clear_queues();
      #1;
      check("midrst out_valid", 64'(out_valid), 64'(0));
      check("midrst out_data", out_data, 64'(0));
      next_cycle();
      rst = 1'b0;
      #1;
      check("midrst in_ready", 64'(in_ready), 64'(1));
      next_cycle();

      // ---------------- vector table ----------------
      for (int i = 0; i < 14; i++) begin
         in_sel    = vecs[i].sel;
         in_data   = vecs[i].data;
         in_valid  = vecs[i].valid;
         out_ready = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
         check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ovalid));
         next_cycle();
      end
      drain("table");

      // ---------------- full with simultaneous pop ----------------
      out_ready = '0;
      send(2'd0, 16'h0001);
      send(2'd0, 16'h0002);
      in_sel = 2'd0; in_data = 16'h0003; in_valid = 1'b1; out_ready = 4'b0001;
      #1;
      check("full+pop refused", 64'(in_ready), 64'(0));
      next_cycle();
      out_ready = 4'b0000;
      #1;
      check("full+pop accepted next", 64'(in_ready), 64'(1));
      next_cycle();
      in_valid = 1'b0;
      check("ch0 head after refill", 64'(out_data[0 +: W]), 64'(16'h0002));
      drain("fullpop");

      // ---------------- wrap-around with random stalls ----------------
      begin
         int n = 0;
         int cyc = 0;
         while (n < 10 && cyc < 300) begin
            in_sel = 2'd2; in_data = W'(n); in_valid = 1'b1;
            out_ready = '0;
            out_ready[2] = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) n++;
            next_cycle();
            cyc++;
         end
         check("wrap all sent", 64'(n), 64'(10));
      end
      drain("wrap");

`ifdef DMUX_STREAM_BCAST_EN
      // ---------------- broadcast ----------------
      out_ready = '0;
      send(2'd3, 16'h3001);
      send(2'd3, 16'h3002);
      in_bcast = 1'b1; in_sel = 2'd0; in_data = 16'hBEEF; in_valid = 1'b1;
      #1;
      check("bcast blocked", 64'(in_ready), 64'(0));
      out_ready = 4'b1000;
      next_cycle();
      out_ready = '0;
      #1;
      check("bcast accepted", 64'(in_ready), 64'(1));
      next_cycle();
      idle_inputs();
      check("bcast ch0", 64'(out_data[0*W +: W]), 64'(16'hBEEF));
      check("bcast ch3 head", 64'(out_data[3*W +: W]), 64'(16'h3002));
      drain("bcast");
`endif

      check("queues empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()
                                + exp_q[3].size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
